// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with a one-word holding buffer and frame markers.
// Words load over a valid/ready port; bits leave one per serial valid/ready transfer.
module piso_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  output logic             ser_out_o,
  output logic             ser_valid_o,
  input  logic             ser_ready_i,
  output logic             frame_start_o,
  output logic             frame_end_o,
  output logic             busy_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StShift = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] hbuf_q, hbuf_d;
  logic             hfull_q, hfull_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic accept, xfer, last_bit;
  logic [WIDTH-1:0] sh_shifted;

  assign load_ready_o = !hfull_q && !rst_i;
  assign ser_valid_o  = (state_q == StShift);
  assign accept       = load_valid_i && load_ready_o;
  assign xfer         = ser_valid_o && ser_ready_i;
  assign last_bit     = (cnt_q == CntLast);

  // Move the next bit toward the output end, zero-filling behind it.
  assign sh_shifted = MSB_FIRST ? (sh_q << 1) : (sh_q >> 1);

  always_comb begin
    ser_out_o = 1'b0;
    if (ser_valid_o) begin
      ser_out_o = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];
    end
  end

  assign frame_start_o = ser_valid_o && (cnt_q == '0);
  assign frame_end_o   = ser_valid_o && last_bit;
  assign busy_o        = ser_valid_o || hfull_q;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    hbuf_d  = hbuf_q;
    hfull_d = hfull_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          sh_d    = d_i;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (xfer && last_bit) begin
          // A held word wins; otherwise a same-cycle load bypasses the holding buffer.
          if (hfull_q) begin
            sh_d    = hbuf_q;
            hfull_d = 1'b0;
            cnt_d   = '0;
          end else if (accept) begin
            sh_d  = d_i;
            cnt_d = '0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          if (xfer) begin
            sh_d  = sh_shifted;
            cnt_d = cnt_q + CntW'(1);
          end
          if (accept) begin
            hbuf_d  = d_i;
            hfull_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      sh_q    <= '0;
      hbuf_q  <= '0;
      hfull_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      hbuf_q  <= hbuf_d;
      hfull_q <= hfull_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share stimulus and are checked
// against a word-queue reference model, a directed vector table and multi-cycle sequences.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] d;
  logic       lv, sr;
  logic lr_m, so_m, sv_m, fs_m, fe_m, busy_m;
  logic lr_l, so_l, sv_l, fs_l, fe_l, busy_l;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk_i(clk), .rst_i(rst), .d_i(d), .load_valid_i(lv), .load_ready_o(lr_m),
    .ser_out_o(so_m), .ser_valid_o(sv_m), .ser_ready_i(sr), .frame_start_o(fs_m),
    .frame_end_o(fe_m), .busy_o(busy_m)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk_i(clk), .rst_i(rst), .d_i(d), .load_valid_i(lv), .load_ready_o(lr_l),
    .ser_out_o(so_l), .ser_valid_o(sv_l), .ser_ready_i(sr), .frame_start_o(fs_l),
    .frame_end_o(fe_l), .busy_o(busy_l)
  );

  // Model: queue of accepted words (front one is on the wire) and bits already sent of it.
  logic [7:0] mq[$];
  int         pos = 0;
  int         total = 0;
  int         bad = 0;

  typedef struct {
    logic       lv;
    logic [7:0] d;
    logic       sr;
    logic       e_sv, e_so_m, e_so_l, e_fs, e_fe, e_busy, e_lr;
  } vec_t;
  vec_t vt[10];

  task automatic chk(input string name, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %b want %b", name, $time, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d want %0d", name, $time, got, exp);
    end
  endtask

  function automatic logic model_bit(input bit msb);
    logic [7:0] w;
    if (mq.size() == 0) return 1'b0;
    w = mq[0];
    return msb ? w[7-pos] : w[pos];
  endfunction

  // Check outputs against the model, then advance one clock and update the model.
  task automatic tick();
    logic       ev, acc, xf;
    logic [7:0] dd;
    #2;
    ev = (mq.size() != 0);
    chk("load_ready_m", lr_m, !rst && mq.size() < 2);
    chk("load_ready_l", lr_l, !rst && mq.size() < 2);
    chk("ser_valid_m", sv_m, ev);
    chk("ser_valid_l", sv_l, ev);
    chk("ser_out_m", so_m, model_bit(1'b1));
    chk("ser_out_l", so_l, model_bit(1'b0));
    chk("frame_start_m", fs_m, ev && pos == 0);
    chk("frame_start_l", fs_l, ev && pos == 0);
    chk("frame_end_m", fe_m, ev && pos == 7);
    chk("frame_end_l", fe_l, ev && pos == 7);
    chk("busy_m", busy_m, ev);
    chk("busy_l", busy_l, ev);
    acc = lv && !rst && mq.size() < 2;
    xf  = ev && sr && !rst;
    dd  = d;
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
      pos = 0;
    end else begin
      if (xf) begin
        pos++;
        if (pos == 8) begin
          void'(mq.pop_front());
          pos = 0;
        end
      end
      if (acc) mq.push_back(dd);
    end
  endtask

  task automatic drain(input string name);
    lv = 1'b0;
    sr = 1'b1;
    for (int k = 0; k < 40 && mq.size() != 0; k++) tick();
    tick();
    chk(name, busy_m, 1'b0);
  endtask

  task automatic send_one(input logic [7:0] w);
    lv = 1'b1;
    d  = w;
    tick();
    lv = 1'b0;
    drain("drain_single");
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] words[3];
    int         idx, vcount, first, last, cycles, stalls;
    logic       acc;

    rst = 1'b1; lv = 1'b0; sr = 1'b0; d = '0;
    tick();
    tick();
    rst = 1'b0;

    // Directed table: 0xA5 reads the same either way round.
    pat = 8'hA5;
    vt[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 1; i <= 8; i++) begin
      vt[i] = '{1'b0, 8'h00, 1'b1, 1'b1, pat[8-i], pat[i-1], i == 1, i == 8, 1'b1, 1'b1};
    end
    vt[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 10; i++) begin
      lv = vt[i].lv; d = vt[i].d; sr = vt[i].sr;
      #2;
      chk("tbl_valid", sv_m, vt[i].e_sv);
      chk("tbl_out_m", so_m, vt[i].e_so_m);
      chk("tbl_out_l", so_l, vt[i].e_so_l);
      chk("tbl_fs", fs_m, vt[i].e_fs);
      chk("tbl_fe", fe_l, vt[i].e_fe);
      chk("tbl_busy", busy_m, vt[i].e_busy);
      chk("tbl_ready", lr_l, vt[i].e_lr);
      tick();
    end

    send_one(8'h01);

    // Back-to-back words with load_valid held: 24 contiguous valid bits.
    words[0] = 8'hF0; words[1] = 8'h0F; words[2] = 8'h3C;
    idx = 0; vcount = 0; first = -1; last = -1;
    sr = 1'b1;
    for (int k = 0; k < 60 && (idx < 3 || mq.size() != 0); k++) begin
      lv = (idx < 3);
      d  = (idx < 3) ? words[idx] : 8'h00;
      #1;
      if (sv_m) begin
        vcount++;
        if (first < 0) first = k;
        last = k;
      end
      acc = lv && mq.size() < 2;
      tick();
      if (acc) idx++;
    end
    chk_int("b2b_valid_bits", vcount, 24);
    chk_int("b2b_no_gaps", last - first + 1, 24);
    drain("drain_b2b");

    // Stall pattern 1,0,0,1,... while 0xC3 shifts out.
    lv = 1'b1; d = 8'hC3; sr = 1'b0;
    tick();
    lv = 1'b0;
    cycles = 0; stalls = 0;
    for (int k = 0; k < 40; k++) begin
      sr = (k % 4 == 0) || (k % 4 == 3);
      #1;
      if (sv_m) begin
        cycles++;
        if (!sr) stalls++;
      end
      tick();
    end
    chk_int("stall_cycles", cycles, 8 + stalls);
    drain("drain_stall");

    // Load on the last-bit cycle with the holding buffer empty: bypass, no gap.
    lv = 1'b1; d = 8'h81; sr = 1'b1;
    tick();
    lv = 1'b0;
    for (int k = 0; k < 20 && pos != 7; k++) tick();
    lv = 1'b1; d = 8'h7E;
    tick();
    lv = 1'b0;
    #2;
    chk("bypass_valid", sv_m, 1'b1);
    chk("bypass_fs", fs_l, 1'b1);
    drain("drain_bypass");

    // Reset mid-word with a held word behind it.
    lv = 1'b1; d = 8'hFF; sr = 1'b1;
    tick();
    d = 8'h11;
    tick();
    lv = 1'b0;
    for (int k = 0; k < 20 && pos != 3; k++) tick();
    rst = 1'b1;
    mq.delete();
    pos = 0;
    #2;
    chk("rst_valid", sv_m, 1'b0);
    chk("rst_busy", busy_l, 1'b0);
    chk("rst_ready", lr_m, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    send_one(8'h55);

    // Randomized traffic against the model.
    for (int k = 0; k < 500; k++) begin
      lv = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      sr = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain("drain_random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in serial-out transmitter with a one-word holding buffer. Accepts WIDTH-bit words over a valid/ready load port and shifts them out one bit per transfer on a valid/ready serial port, with frame markers on the first and last bit. It is the serial-side counterpart of the parallel capture registers in this library. It feeds serial links and shift-chain consumers, including a matching deserializer.

## Interface
- WIDTH, 8, word width in bits (≥ 2)
- MSB_FIRST, 1, 1 = bit WIDTH-1 sent first, 0 = bit 0 sent first

- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- d  input  WIDTH  parallel word to load
- load_valid  input  1  d is valid
- load_ready  output  1  block can accept a word this cycle
- ser_out  output  1  current serial bit
- ser_valid  output  1  ser_out is valid
- ser_ready  input  1  downstream takes ser_out this cycle
- frame_start  output  1  ser_out is the first bit of a word
- frame_end  output  1  ser_out is the last bit of a word
- busy  output  1  a word is shifting or held

## Operation
- State: shift register sh[WIDTH-1:0], bit counter cnt (0..WIDTH-1), holding register hbuf[WIDTH-1:0], flag hfull, FSM {IDLE, SHIFT}.
- Load accept: load_valid && load_ready. load_ready = !hfull && !rst. It depends only on registered state and rst, not on ser_ready.
- Serial transfer: ser_valid && ser_ready. ser_valid = (state == SHIFT).
- ser_out = sh[WIDTH-1] if MSB_FIRST, else sh[0]. Forced 0 when ser_valid = 0.
- frame_start = ser_valid && cnt == 0. frame_end = ser_valid && cnt == WIDTH-1.
- busy = (state == SHIFT) || hfull.
- IDLE + accept: sh ← d, cnt ← 0, go to SHIFT. hbuf is unused.
- SHIFT + accept: hbuf ← d, hfull ← 1.
- SHIFT + transfer, cnt < WIDTH-1: shift sh one position toward the output end (fill with 0), cnt ← cnt+1.
- SHIFT + transfer, cnt == WIDTH-1 (last bit):
  - If hfull: sh ← hbuf, hfull ← 0, cnt ← 0, stay in SHIFT.
  - Else, if an accept occurs in the same cycle: sh ← d, cnt ← 0, stay in SHIFT. The word bypasses hbuf.
  - Else: go to IDLE.
- SHIFT without a transfer (ser_ready = 0): sh and cnt hold; ser_out stays stable.
- At most one word is held beyond the word shifting. A third word stalls on load_ready = 0.

## Timing
- Reset (async assert, sync release): state = IDLE, sh = 0, hbuf = 0, hfull = 0, cnt = 0.
- Output values during and after reset:
  - load_ready = 0 while rst is high, 1 after release.
  - ser_out, ser_valid, frame_start, frame_end and busy are all 0.
- Reset mid-word: the partial word and the held word are discarded; no further bits are emitted.
- Latency: an accept in IDLE at edge N gives ser_valid = 1 with the first bit from edge N+1.
- Throughput: with ser_ready held at 1 and words available, there are no gap cycles between words; frame_end of word k is followed on the next cycle by frame_start of word k+1.
- A WIDTH-bit word takes exactly WIDTH transfers. Stalls extend this by one cycle per ser_ready = 0 cycle.
- Handshake rules:
  - ser_out and the frame markers must not change while ser_valid && !ser_ready.
  - d is sampled only on an accept.

## Test plan
- WIDTH=8, MSB_FIRST=1, load d=0xA5 from IDLE, ser_ready=1 → ser_out 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting one cycle after accept. frame_start on bit 1, frame_end on bit 8. Then IDLE, busy=0.
- MSB_FIRST=0, d=0xA5 → ser_out 1,0,1,0,0,1,0,1 (LSB first; the bits read the same as above because 0xA5 is a bit-palindrome); repeat with d=0x01 → 1,0,0,0,0,0,0,0.
- Back-to-back 0xF0, 0x0F, 0x3C with load_valid held and ser_ready=1 → 24 contiguous valid bits with no gaps. load_ready=0 while hbuf is full. A third word is accepted only after hbuf drains.
- ser_ready toggled 1,0,0,1,… during 0xC3 → ser_out holds during stall cycles, the bit sequence is unchanged, and total cycles = 8 + stall count.
- Accept on the last-bit cycle with hbuf empty (0x81 then 0x7E) → the second word starts on the very next cycle via bypass, frame_start=1.
- Assert rst after the 3rd bit of 0xFF with a held word → on the next sample ser_valid=0, busy=0, load_ready=0 during rst. After release, a new 0x55 serializes correctly from its first bit.
